// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and helpers for the 8-to-3 event encoder.
package enc_pkg;

    localparam int unsigned IDX_W_DEF = 3;
    localparam int unsigned N_DEF     = 2 ** IDX_W_DEF;

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } state_e;

    function automatic logic [N_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
        onehot = N_DEF'(1) << idx;
    endfunction

endpackage

// File: rtl/enc_ffs.sv
// Combinational find-first-set over N bits, searching upward from a start index and wrapping.
module enc_ffs
    import enc_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    localparam int unsigned N    = 2 ** IDX_W
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;

    // Rotating right by start puts the search origin at bit 0.
    assign dbl = {vec, vec};
    assign rot = dbl[start +: N];

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign idx = off + start;

endmodule

// File: rtl/enc8x3_evt.sv
// Sequential 8-to-3 event encoder: captures event lines into a pending register and reports
// them one at a time over VLD/RDY. Define ENC_RR_EN for round-robin instead of lowest-first.
module enc8x3_evt
    import enc_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    localparam int unsigned N    = 2 ** IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [N-1:0]     I,
    output logic [IDX_W-1:0] A,
    output logic             VLD,
    input  logic             RDY,
    output logic [N-1:0]     PEND,
    output logic             OVF
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] a_q, a_d;
    logic             vld_q, vld_d;
    logic [N-1:0]     pend_q, pend_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             load;
    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic [N-1:0]     clr;
    logic [N-1:0]     set;

    assign accept = vld_q & RDY;

`ifdef ENC_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // On accept the new search must already begin after the index being retired.
    assign start = accept ? a_q + IDX_W'(1) : ptr_q;
    assign ptr_d = accept ? a_q + IDX_W'(1) : ptr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    enc_ffs #(
        .IDX_W (IDX_W)
    ) u_ffs (
        .vec   (pend_q),
        .start (start),
        .idx   (sel),
        .found (found)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (accept) begin
                    if (found) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        clr    = load ? (N'(1) << sel) : '0;
        set    = EN ? I : '0;
        // Set wins over clear on the same bit, so a collision re-pends the line.
        pend_d = (pend_q & ~clr) | set;
        ovf_d  = ovf_q | (|(set & pend_q & ~clr));
        a_d    = load ? sel : a_q;
        vld_d  = load ? 1'b1 : (accept ? 1'b0 : vld_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            a_q     <= '0;
            vld_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            vld_q   <= vld_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign A    = a_q;
    assign VLD  = vld_q;
    assign PEND = pend_q;
    assign OVF  = ovf_q;

endmodule
